// File: rtl/cic_interpolator.sv
// cic_interpolator
//   Interpolate-by-R CIC filter for the transmit path. Low-rate signed samples
//   enter through a valid/ready handshake, one per R clocks. They pass through
//   N comb stages at the input rate, are zero-stuffed, and then go through N
//   integrators at the clock rate. The R^(N-1) gain is removed by slicing, so
//   the DC gain is unity.
// Ports
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : run request; low finishes the current frame, then flushes
//   in_valid   : d_in holds a sample
//   in_ready   : d_in is accepted this cycle when in_valid is also high
//   d_in       : signed input sample (IN_W bits)
//   out_valid  : d_out holds a filter output
//   d_out      : signed full-rate output sample (OUT_W bits)
//   underrun   : one-cycle pulse after a RUN sample slot with no input
//   busy       : high in RUN or FLUSH
module cic_interpolator #(
  parameter int R     = 8,
  parameter int N     = 3,
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  d_in,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] d_out,
  output logic                    underrun,
  output logic                    busy
);

  localparam int LR = (R > 1) ? $clog2(R) : 1;
  localparam int W  = IN_W + (N - 1) * $clog2(R);
  localparam int FW = $clog2(N * R) + 1;
  localparam int VW = $clog2(N + 3);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [LR-1:0]         phase_q, phase_d;
  logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
  logic [VW-1:0]         vcnt_q, vcnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  slot_q, slot_d;
  logic signed [W-1:0]   dly_q [N];
  logic signed [W-1:0]   dly_d [N];
  logic signed [W-1:0]   comb_out_q, comb_out_d;
  logic signed [W-1:0]   inj_q, inj_d;
  logic signed [W-1:0]   integ_q [N];
  logic signed [W-1:0]   integ_d [N];
  logic signed [OUT_W-1:0] d_out_q, d_out_d;

  logic                  last;
  logic                  accept;
  logic                  comb_step;
  logic                  clear;
  logic signed [W-1:0]   x;
  logic signed [W-1:0]   cv [N+1];

  assign last     = (phase_q == LR'(R - 1));
  assign in_ready = rst_n & en & ((state_q == IDLE) | ((state_q == RUN) & last));
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;
  assign d_out     = d_out_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    flush_cnt_d = flush_cnt_q;
    vcnt_d      = vcnt_q;
    underrun_d  = 1'b0;
    comb_step   = 1'b0;
    clear       = 1'b0;
    x           = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = RUN;
          phase_d   = '0;
          vcnt_d    = '0;
          comb_step = 1'b1;
          x         = W'(d_in);
        end
      end
      RUN: begin
        phase_d = phase_q + 1'b1;
        // Every slot clocks the comb; a missing sample or the frame end feeds zero.
        if (last) begin
          comb_step = 1'b1;
          if (accept) x = W'(d_in);
          if (!en) begin
            state_d     = FLUSH;
            flush_cnt_d = FW'(N * R - 1);
          end else if (!in_valid) begin
            underrun_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = IDLE;
          phase_d = '0;
          vcnt_d  = '0;
          clear   = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
          phase_d     = phase_q + 1'b1;
          comb_step   = last;
        end
      end
      default: state_d = IDLE;
    endcase

    // out_valid rises N+2 clocks after the first accept, once the first
    // dependent sample has reached d_out.
    if (state_q != IDLE && state_d != IDLE && vcnt_q != VW'(N + 2))
      vcnt_d = vcnt_q + 1'b1;
    out_valid_d = (state_d != IDLE) && (vcnt_d == VW'(N + 2));

    cv[0] = x;
    for (int unsigned k = 0; k < N; k++)
      cv[k+1] = cv[k] - dly_q[k];
    for (int unsigned k = 0; k < N; k++)
      dly_d[k] = comb_step ? cv[k] : dly_q[k];
    comb_out_d = comb_step ? cv[N] : comb_out_q;
    slot_d     = comb_step;

    // Zero-stuffing: the comb result is injected only in the cycle after a slot.
    inj_d = slot_q ? comb_out_q : '0;

    integ_d[0] = integ_q[0] + inj_q;
    for (int unsigned k = 1; k < N; k++)
      integ_d[k] = integ_q[k] + integ_q[k-1];

    d_out_d = integ_q[N-1][W-1 -: OUT_W];

    if (clear) begin
      for (int unsigned k = 0; k < N; k++) begin
        dly_d[k]   = '0;
        integ_d[k] = '0;
      end
      comb_out_d = '0;
      slot_d     = 1'b0;
      inj_d      = '0;
      d_out_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      flush_cnt_q <= '0;
      vcnt_q      <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      slot_q      <= 1'b0;
      comb_out_q  <= '0;
      inj_q       <= '0;
      d_out_q     <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        dly_q[k]   <= '0;
        integ_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      flush_cnt_q <= flush_cnt_d;
      vcnt_q      <= vcnt_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
      slot_q      <= slot_d;
      comb_out_q  <= comb_out_d;
      inj_q       <= inj_d;
      d_out_q     <= d_out_d;
      for (int unsigned k = 0; k < N; k++) begin
        dly_q[k]   <= dly_d[k];
        integ_q[k] <= integ_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator
//   Directed bench for cic_interpolator. A reference FSM tracks sample slots;
//   every accepted sample pushes its scaled impulse response (boxcar^N) into a
//   time-aligned scoreboard queue that is popped once per clock and compared
//   with d_out. Handshake/status outputs are compared against the reference FSM.
module tb_cic_interpolator;

  localparam int R     = 8;
  localparam int N     = 3;
  localparam int IN_W  = 8;
  localparam int OUT_W = 8;
  localparam int HL    = N * (R - 1) + 1;
  localparam int LAT   = N + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic in_valid = 1'b0;
  logic signed [IN_W-1:0] d_in = '0;
  logic in_ready;
  logic out_valid;
  logic signed [OUT_W-1:0] d_out;
  logic underrun;
  logic busy;

  always #5 clk = ~clk;

  cic_interpolator #(.R(R), .N(N), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .d_in(d_in), .out_valid(out_valid), .d_out(d_out), .underrun(underrun), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int ur_seen = 0;
  int h [HL];

  typedef enum {M_IDLE, M_RUN, M_FLUSH} mstate_t;
  mstate_t m_state = M_IDLE;
  mstate_t m_prev  = M_IDLE;
  int   m_phase = 0;
  int   m_fcnt  = 0;
  int   m_vcnt  = 0;
  logic m_ov    = 1'b0;
  logic m_ur    = 1'b0;
  logic m_last  = 1'b0;
  logic m_acc   = 1'b0;
  int   cyc     = 0;
  int   sb_base = 0;
  int   sb [$];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic exp_ready();
    return rst_n && en && (m_state == M_IDLE || (m_state == M_RUN && m_phase == R - 1));
  endfunction

  task automatic sb_add(input int t, input int v);
    int idx;
    if (sb.size() == 0) sb_base = cyc;
    idx = t - sb_base;
    while (sb.size() <= idx) sb.push_back(0);
    sb[idx] += v;
  endtask

  // Reference FSM and scoreboard producer
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = M_IDLE; m_phase = 0; m_fcnt = 0; m_vcnt = 0;
      m_ov = 1'b0; m_ur = 1'b0;
      sb.delete();
    end else begin
      cyc++;
      m_last = (m_phase == R - 1);
      m_acc  = in_valid && exp_ready();
      m_ur   = (m_state == M_RUN) && m_last && en && !in_valid;
      if (m_acc)
        for (int n = 0; n < HL; n++) sb_add(cyc + LAT + n, int'(d_in) * h[n]);
      m_prev = m_state;
      case (m_state)
        M_IDLE: if (m_acc) begin m_state = M_RUN; m_phase = 0; m_vcnt = 0; end
        M_RUN: begin
          if (m_last && !en) begin m_state = M_FLUSH; m_fcnt = N * R - 1; end
          m_phase = (m_phase + 1) % R;
        end
        M_FLUSH: begin
          if (m_fcnt == 0) begin m_state = M_IDLE; m_phase = 0; end
          else begin m_fcnt--; m_phase = (m_phase + 1) % R; end
        end
      endcase
      if (m_prev != M_IDLE && m_state != M_IDLE) begin
        if (m_vcnt < LAT) m_vcnt++;
        m_ov = (m_vcnt == LAT);
      end else begin
        m_ov = 1'b0;
      end
    end
  end

  // Monitor: compare every output once per clock, away from the active edge
  always @(negedge clk) begin
    int v;
    logic [31:0] vv;
    logic signed [OUT_W-1:0] expd;
    if (underrun === 1'b1) ur_seen++;
    if (sb.size() == 0) sb_base = cyc;
    while (sb_base < cyc) begin
      void'(sb.pop_front());
      sb_base++;
    end
    v    = (sb.size() > 0) ? sb[0] : 0;
    vv   = v;
    expd = vv[13:6];
    check("in_ready", in_ready, exp_ready());
    check("busy", busy, m_state != M_IDLE);
    check("underrun", underrun, m_ur);
    check("out_valid", out_valid, m_ov);
    check("d_out", d_out, expd);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (busy && i < 100) begin
      tick(1);
      i++;
    end
    check(tag, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check({tag, "_dout"}, d_out, 0);
    check({tag, "_ovalid"}, out_valid, 0);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tmp [HL];
    int len;
    foreach (h[i]) h[i] = 0;
    h[0] = 1;
    len = 1;
    repeat (N) begin
      foreach (tmp[i]) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R; j++) tmp[i+j] += h[i];
      len += R - 1;
      h = tmp;
    end

    // Reset state (en high to confirm in_ready is held low in reset)
    en = 1'b1;
    tick(2);
    check_reset_outputs("reset");
    en = 1'b0;
    rst_n = 1'b1;
    tick(2);

    // Test 1: constant 64 step response
    en = 1'b1; in_valid = 1'b1; d_in = 8'sd64;
    tick(40);
    check("t1_settle", d_out, 64);
    check("t1_ovalid", out_valid, 1);

    // Test 2: full-scale DC both polarities
    d_in = 8'sd127;
    tick(40);
    check("t2_pos_fs", d_out, 127);
    d_in = -8'sd128;
    tick(40);
    check("t2_neg_fs", d_out, -128);

    // Test 4: one missed slot
    ur_seen = 0;
    in_valid = 1'b0;
    tick(8);
    in_valid = 1'b1;
    tick(2);
    check("t4_underrun_cnt", ur_seen, 1);
    tick(30);

    // Random stream (exercises internal modulo wrap)
    for (int i = 0; i < 48; i++) begin
      d_in = 8'($urandom_range(0, 255));
      tick(1);
    end

    // Test 5: frame end, flush, return to IDLE
    en = 1'b0;
    wait_idle("t5_idle_timeout");
    tick(2);
    check("t5_ovalid", out_valid, 0);
    check("t5_dout", d_out, 0);

    // Test 3: single impulse followed by zeros
    en = 1'b1; in_valid = 1'b1; d_in = 8'sd64;
    tick(1);
    d_in = '0;
    tick(40);
    check("t3_tail", d_out, 0);

    // Test 6a: reset during RUN, then restart
    d_in = 8'sd64;
    tick(20);
    rst_n = 1'b0;
    check_reset_outputs("t6_run_rst");
    tick(2);
    rst_n = 1'b1;
    tick(40);
    check("t6_restart1", d_out, 64);

    // Test 6b: reset during FLUSH, then restart
    en = 1'b0;
    tick(12);
    check("t6_in_flush", busy, 1);
    rst_n = 1'b0;
    check_reset_outputs("t6_flush_rst");
    en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(40);
    check("t6_restart2", d_out, 64);

    en = 1'b0;
    wait_idle("t6_idle_timeout");
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
